// File: rtl/dec_scan_sel_if.sv
// dec_scan_sel_if
// ---------------
// Bundles the enable/mode/select/dwell inputs and the strobe/index/wrap
// outputs of dec_scan_sel.
//   master : drives G_L, MODE, SEL, DWELL (and SKIP); observes Y_L, CUR, WRAP
//   slave  : the decoder side
// Optional macro DEC_SCAN_SKIP_EN adds the SKIP channel mask.
interface dec_scan_sel_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int NCH = 2 ** SEL_W;

    logic               G_L;
    logic               MODE;
    logic [SEL_W-1:0]   SEL;
    logic [DWELL_W-1:0] DWELL;
    logic [NCH-1:0]     Y_L;
    logic [SEL_W-1:0]   CUR;
    logic               WRAP;
`ifdef DEC_SCAN_SKIP_EN
    logic [NCH-1:0]     SKIP;

    modport master (output G_L, MODE, SEL, DWELL, SKIP, input Y_L, CUR, WRAP);
    modport slave  (input G_L, MODE, SEL, DWELL, SKIP, output Y_L, CUR, WRAP);
`else
    modport master (output G_L, MODE, SEL, DWELL, input Y_L, CUR, WRAP);
    modport slave  (input G_L, MODE, SEL, DWELL, output Y_L, CUR, WRAP);
`endif
endinterface

// File: rtl/dec_scan_sel.sv
// dec_scan_sel
// ------------
// Registered, parametrised active-low decoder with an optional scanning
// sequencer for digit/row multiplexing.
//   CLK   : clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : dec_scan_sel_if.slave
//           G_L   active-low enable
//           MODE  0 = direct decode of SEL, 1 = scan through all channels
//           SEL   direct-mode channel select
//           DWELL scan dwell, each channel is active DWELL+1 cycles
//           Y_L   registered active-low strobes, at most one bit low
//           CUR   registered index of the current/last active channel
//           WRAP  one-cycle pulse on the first cycle of a wrapped channel
// Parameters: SEL_W (select width), DWELL_W (DWELL width), BLANK_CYC
// (all-high cycles between scanned channels, 0 = none).
// Optional macro DEC_SCAN_SKIP_EN: adds SKIP; scanning then visits only
// channels whose SKIP bit is 0, and idles when every channel is skipped.
module dec_scan_sel #(
    parameter int SEL_W     = 2,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    dec_scan_sel_if.slave bus
);
    localparam int NCH     = 2 ** SEL_W;
    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_BLANK  = 2'd3;

    localparam logic [NCH-1:0] ALL_HIGH = {NCH{1'b1}};

    // Active-low one-cold strobe for a channel index.
    function automatic logic [NCH-1:0] strobe_low(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] v;
        v      = {NCH{1'b1}};
        v[idx] = 1'b0;
        return v;
    endfunction

`ifdef DEC_SCAN_SKIP_EN
    // First non-skipped channel at or after 'start', searching cyclically.
    function automatic logic [SEL_W-1:0] first_free(input logic [SEL_W-1:0] start,
                                                    input logic [NCH-1:0]   skip);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] found;
        logic             hit;
        found = start;
        hit   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = start + SEL_W'(k);
            if (!hit && !skip[idx]) begin
                found = idx;
                hit   = 1'b1;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction
`endif

    logic [1:0]         state_r, state_s;
    logic [NCH-1:0]     y_l_r, y_l_s;
    logic [SEL_W-1:0]   cur_r, cur_s;
    logic               wrap_r, wrap_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [BLANK_W-1:0] blank_r, blank_s;

    logic [SEL_W-1:0]   entry_idx_s;
    logic [SEL_W-1:0]   adv_idx_s;
    logic               adv_wrap_s;
    logic               none_free_s;
    logic               do_adv_s;

    // Channel selection for scan entry and for advancing to the next channel.
    always_comb begin
`ifdef DEC_SCAN_SKIP_EN
        none_free_s = &bus.SKIP;
        entry_idx_s = first_free({SEL_W{1'b0}}, bus.SKIP);
        adv_idx_s   = first_free(cur_r + SEL_W'(1), bus.SKIP);
        // A cyclic search that lands at or below the current index wrapped.
        adv_wrap_s  = (adv_idx_s <= cur_r);
`else
        none_free_s = 1'b0;
        entry_idx_s = {SEL_W{1'b0}};
        adv_idx_s   = cur_r + SEL_W'(1);
        adv_wrap_s  = (cur_r == {SEL_W{1'b1}});
`endif
    end

    // Next-state and next-output logic for the direct/scan sequencer.
    always_comb begin
        state_s  = state_r;
        y_l_s    = y_l_r;
        cur_s    = cur_r;
        wrap_s   = 1'b0;
        cnt_s    = cnt_r;
        blank_s  = blank_r;
        do_adv_s = 1'b0;

        if (bus.G_L) begin
            state_s = ST_IDLE;
            y_l_s   = ALL_HIGH;
        end else if (!bus.MODE) begin
            state_s = ST_DIRECT;
            y_l_s   = strobe_low(bus.SEL);
            cur_s   = bus.SEL;
        end else if (none_free_s) begin
            state_s = ST_IDLE;
            y_l_s   = ALL_HIGH;
        end else begin
            case (state_r)
                ST_ON: begin
                    if (cnt_r != {DWELL_W{1'b0}}) begin
                        cnt_s = cnt_r - DWELL_W'(1);
                    end else if (BLANK_CYC > 0) begin
                        state_s = ST_BLANK;
                        y_l_s   = ALL_HIGH;
                        blank_s = BLANK_W'(BLANK_CYC - 1);
                    end else begin
                        do_adv_s = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blank_r != {BLANK_W{1'b0}}) begin
                        blank_s = blank_r - BLANK_W'(1);
                    end else begin
                        do_adv_s = 1'b1;
                    end
                end
                default: begin
                    // IDLE or DIRECT: (re)start the scan at the first channel.
                    state_s = ST_ON;
                    cur_s   = entry_idx_s;
                    y_l_s   = strobe_low(entry_idx_s);
                    cnt_s   = bus.DWELL;
                end
            endcase
        end

        if (do_adv_s) begin
            state_s = ST_ON;
            cur_s   = adv_idx_s;
            y_l_s   = strobe_low(adv_idx_s);
            cnt_s   = bus.DWELL;
            wrap_s  = adv_wrap_s;
        end else begin
            state_s = state_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            y_l_r   <= ALL_HIGH;
            cur_r   <= {SEL_W{1'b0}};
            wrap_r  <= 1'b0;
            cnt_r   <= {DWELL_W{1'b0}};
            blank_r <= {BLANK_W{1'b0}};
        end else begin
            state_r <= state_s;
            y_l_r   <= y_l_s;
            cur_r   <= cur_s;
            wrap_r  <= wrap_s;
            cnt_r   <= cnt_s;
            blank_r <= blank_s;
        end
    end

    assign bus.Y_L  = y_l_r;
    assign bus.CUR  = cur_r;
    assign bus.WRAP = wrap_r;
endmodule

// File: tb/tb_dec_scan_sel.sv
// tb_dec_scan_sel: directed vector table, hand-written scan/reset/skip
// sequences, and a random phase checked against an arithmetic model.
// Two instances share the stimulus: BLANK_CYC=1 and BLANK_CYC=0.
module tb_dec_scan_sel;
    logic       clk = 1'b0;
    logic       rst;
    logic       g_l;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] skip;

    int errs   = 0;
    int checks = 0;

    dec_scan_sel_if #(.SEL_W(2), .DWELL_W(8)) bus1 ();
    dec_scan_sel_if #(.SEL_W(2), .DWELL_W(8)) bus0 ();

    assign bus1.G_L = g_l;  assign bus1.MODE = mode;
    assign bus1.SEL = sel;  assign bus1.DWELL = dwell;
    assign bus0.G_L = g_l;  assign bus0.MODE = mode;
    assign bus0.SEL = sel;  assign bus0.DWELL = dwell;
`ifdef DEC_SCAN_SKIP_EN
    assign bus1.SKIP = skip;
    assign bus0.SKIP = skip;
`endif

    dec_scan_sel #(.SEL_W(2), .DWELL_W(8), .BLANK_CYC(1)) u_dut1 (
        .CLK(clk), .RESET(rst), .bus(bus1.slave));
    dec_scan_sel #(.SEL_W(2), .DWELL_W(8), .BLANK_CYC(0)) u_dut0 (
        .CLK(clk), .RESET(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       g_l;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] dwell;
        logic [3:0] y;
        logic [1:0] cur;
        logic       wrap;
    } vec_t;

    vec_t vecs [11];

    // Expected Y_L for 17 cycles of a DWELL=2 scan, BLANK_CYC=1 and 0.
    logic [3:0] scan1 [17] = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,4'hB,
                               4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF,4'hE};
    logic [3:0] scan0 [17] = '{4'hE,4'hE,4'hE,4'hD,4'hD,4'hD,4'hB,4'hB,4'hB,
                               4'h7,4'h7,4'h7,4'hE,4'hE,4'hE,4'hD,4'hD};

    // Reference model state
    bit         m_scan;
    int         m_t;
    int         m_d;
    logic [3:0] e1_y, e0_y;
    logic [1:0] e1_c, e0_c;
    logic       e1_w, e0_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scan position derived from elapsed cycles since scan entry.
    function automatic void scan_exp(input int b, input int t, input int d,
                                     output logic [3:0] y, output logic [1:0] c,
                                     output logic w);
        int slot;
        int ch;
        int o;
        slot = d + 1 + b;
        ch   = (t / slot) % 4;
        o    = t % slot;
        y    = (o <= d) ? ~(4'b0001 << ch) : 4'hF;
        c    = 2'(ch);
        w    = (t > 0) && ((t % (4 * slot)) == 0);
    endfunction

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            m_scan = 0;
            e1_y = 4'hF; e0_y = 4'hF; e1_c = 2'd0; e0_c = 2'd0; e1_w = 1'b0; e0_w = 1'b0;
        end else if (g_l) begin
            m_scan = 0;
            e1_y = 4'hF; e0_y = 4'hF; e1_w = 1'b0; e0_w = 1'b0;
        end else if (!mode) begin
            m_scan = 0;
            e1_y = ~(4'b0001 << sel); e0_y = e1_y;
            e1_c = sel; e0_c = sel; e1_w = 1'b0; e0_w = 1'b0;
        end else begin
            if (!m_scan) begin
                m_scan = 1; m_t = 0; m_d = int'(dwell);
            end else begin
                m_t++;
            end
            scan_exp(1, m_t, m_d, e1_y, e1_c, e1_w);
            scan_exp(0, m_t, m_d, e0_y, e0_c, e0_w);
        end
    endtask

    initial begin
        rst = 1'b1; g_l = 1'b0; mode = 1'b1; sel = 2'd0; dwell = 8'd2; skip = 4'b0000;

        //           rst   g_l   mode  sel   dwell  y      cur   wrap
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd2, 4'hF, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd2, 4'hF, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'd2, 4'hE, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 4'hE, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd2, 4'hD, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'd2, 4'hB, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd2, 4'h7, 2'd3, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'd2, 4'hF, 2'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 8'd2, 4'hF, 2'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd2, 4'hD, 2'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'd2, 4'hF, 2'd0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; g_l = vecs[i].g_l; mode = vecs[i].mode;
            sel = vecs[i].sel; dwell = vecs[i].dwell;
            step();
            chk($sformatf("vec%0d_y", i),    32'(bus1.Y_L),  32'(vecs[i].y));
            chk($sformatf("vec%0d_cur", i),  32'(bus1.CUR),  32'(vecs[i].cur));
            chk($sformatf("vec%0d_wrap", i), 32'(bus1.WRAP), 32'(vecs[i].wrap));
        end

        // Full scan with DWELL=2 on both blanking variants.
        rst = 1'b1; g_l = 1'b0; mode = 1'b1; dwell = 8'd2;
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            chk($sformatf("scan1_y%0d", i),    32'(bus1.Y_L),  32'(scan1[i]));
            chk($sformatf("scan1_cur%0d", i),  32'(bus1.CUR),  32'((i / 4) % 4));
            chk($sformatf("scan1_wrap%0d", i), 32'(bus1.WRAP), 32'(i == 16));
            chk($sformatf("scan0_y%0d", i),    32'(bus0.Y_L),  32'(scan0[i]));
            chk($sformatf("scan0_wrap%0d", i), 32'(bus0.WRAP), 32'(i == 12));
        end

        // Reset during the channel-2 phase, then restart at channel 0.
        for (int i = 17; i < 25; i++) step();
        chk("midscan_y", 32'(bus1.Y_L), 32'(4'hB));
        chk("midscan_cur", 32'(bus1.CUR), 32'(2'd2));
        rst = 1'b1;
        step();
        chk("midrst_y", 32'(bus1.Y_L), 32'(4'hF));
        chk("midrst_cur", 32'(bus1.CUR), 32'(2'd0));
        chk("midrst_wrap", 32'(bus1.WRAP), 32'(1'b0));
        rst = 1'b0;
        step();
        chk("restart_y", 32'(bus1.Y_L), 32'(4'hE));
        chk("restart_cur", 32'(bus1.CUR), 32'(2'd0));

`ifdef DEC_SCAN_SKIP_EN
        // Skip channels 0 and 2 with no dwell and no blanking.
        rst = 1'b1;
        step();
        rst = 1'b0; skip = 4'b0101; dwell = 8'd0; g_l = 1'b0; mode = 1'b1;
        step();
        chk("skip_entry_y", 32'(bus0.Y_L), 32'(4'hD));
        chk("skip_entry_wrap", 32'(bus0.WRAP), 32'(1'b0));
        for (int i = 1; i < 7; i++) begin
            step();
            chk($sformatf("skip_y%0d", i), 32'(bus0.Y_L), (i % 2 == 1) ? 32'(4'h7) : 32'(4'hD));
            chk($sformatf("skip_wrap%0d", i), 32'(bus0.WRAP), 32'(i % 2 == 0));
        end
        skip = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("skipall_y%0d", i), 32'(bus0.Y_L), 32'(4'hF));
        end
        skip = 4'b0000;
`endif

        // Random phase against the arithmetic model.
        rst = 1'b1;
        model_step();
        step();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) begin
                g_l  = ($urandom_range(0, 3) == 0);
                mode = ($urandom_range(0, 2) != 0);
            end
            sel = 2'($urandom_range(0, 3));
            if (g_l || !mode) dwell = 8'($urandom_range(0, 4));
            model_step();
            step();
            chk("rnd1_y",    32'(bus1.Y_L),  32'(e1_y));
            chk("rnd1_cur",  32'(bus1.CUR),  32'(e1_c));
            chk("rnd1_wrap", 32'(bus1.WRAP), 32'(e1_w));
            chk("rnd0_y",    32'(bus0.Y_L),  32'(e0_y));
            chk("rnd0_cur",  32'(bus0.CUR),  32'(e0_c));
            chk("rnd0_wrap", 32'(bus0.WRAP), 32'(e0_w));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dec_scan_sel.md
Name: dec_scan_sel

Overview:
- Parametrised, registered successor to the dual 2-to-4 active-low decoder.
- Decodes an SEL_W-bit select into 2**SEL_W active-low strobes, gated by an active-low enable.
- Two modes:
  - direct: decode the SEL input.
  - scan: an internal FSM cycles through channels with a programmable dwell and break-before-make blanking.
- Drives digit/row multiplexing for display and keypad logic.

Parameters:
- SEL_W, 2, select width; output count is 2**SEL_W.
- DWELL_W, 8, width of the DWELL input.
- BLANK_CYC, 1, all-high cycles inserted between scan channels (0 = none).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- G_L  in  1  active-low enable.
- MODE  in  1  0 = direct, 1 = scan.
- SEL  in  SEL_W  direct-mode channel select.
- DWELL  in  DWELL_W  scan dwell; each channel is active DWELL+1 cycles.
- Y_L  out  2**SEL_W  registered active-low strobes; at most one bit is low.
- CUR  out  SEL_W  registered index of the current/last active channel.
- WRAP  out  1  one-cycle pulse when the scan returns to channel 0.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (RESET=1 at an edge): Y_L=all 1s, CUR=0, WRAP=0, state=IDLE, dwell/blank counters=0. Reset takes priority over all other inputs.
- Disabled (G_L=1 at an edge): state=IDLE, Y_L=all 1s next cycle, CUR holds, WRAP=0.
- Direct mode (G_L=0, MODE=0):
  - state=DIRECT.
  - Next cycle Y_L has only bit SEL low, and CUR=SEL.
  - Latency is 1 cycle; SEL changes follow every cycle with no blanking.
- Scan FSM states: IDLE, DIRECT, ON, BLANK.
- Entry to ON: from IDLE or DIRECT when G_L=0 and MODE=1 at an edge.
  - Next cycle: state=ON, CUR=0, Y_L bit 0 low, dwell counter=DWELL (sampled at that edge).
  - WRAP stays 0 on entry.
- ON, each edge:
  - cnt!=0: decrement cnt.
  - cnt==0 and BLANK_CYC>0: go to BLANK with Y_L=all 1s and blank counter=BLANK_CYC-1. CUR holds.
  - cnt==0 and BLANK_CYC==0: advance directly (same as the BLANK-exit advance).
- BLANK, each edge:
  - blank counter!=0: decrement it.
  - otherwise advance: state=ON, CUR=(CUR+1) mod 2**SEL_W, Y_L bit CUR low, cnt=DWELL re-sampled.
- Advance from CUR=2**SEL_W-1 to 0 sets WRAP=1 for exactly that first ON cycle of channel 0.
- Scan period = 2**SEL_W*(DWELL+1+BLANK_CYC) cycles.
- Leaving scan: MODE 1->0 or G_L 0->1 exits the scan on the next cycle (to DIRECT or IDLE).
- Re-entering scan always restarts at channel 0.
- A DWELL change mid-channel takes effect at the next channel load.
- RESET mid-scan: next cycle Y_L=all 1s, CUR=0, IDLE. A scan restarts at channel 0.
- DWELL=0: each channel is active 1 cycle.
- SEL_W=1 is legal; two channels, wrap every second channel.

Optional Feature:
- Macro: DEC_SCAN_SKIP_EN.
- When defined: adds input SKIP (2**SEL_W bits; 1 = skip channel).
  - In scan, the advance and scan entry select the next index, cyclically, whose SKIP bit is 0; skipped channels get no dwell and no blank.
  - WRAP pulses when the selected index is <= the previous one (wrap-around).
  - If SKIP is all 1s, the FSM stays in or returns to IDLE with Y_L=all 1s until a bit clears.
  - SKIP has no effect in direct mode.
- When undefined: the SKIP port is absent and all channels are scanned.

Test Plan (SEL_W=2, BLANK_CYC=1 unless noted):
- Reset: RESET=1 for 2 cycles with G_L=0, MODE=1 -> Y_L=1111, CUR=0, WRAP=0. With G_L=0, MODE=1 held, the first cycle after release still shows Y_L=1111, then Y_L=1110.
- Direct: G_L=0, MODE=0, SEL=0,1,2,3 on successive cycles -> one cycle later Y_L=1110, 1101, 1011, 0111; CUR tracks SEL.
- Disable: G_L=1 with SEL=2, MODE=0 or 1 -> Y_L=1111 next cycle; CUR holds previous value.
- Scan, DWELL=2:
  - Y_L sequence: 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111, then 1110.
  - WRAP=1 only on that first 1110 after 0111 (16-cycle period).
  - With BLANK_CYC=0 the period is 12 and no 1111 cycles appear.
- Reset mid-scan: RESET during the 1011 phase (CUR=2) -> next cycle Y_L=1111, CUR=0; after release the scan restarts at 1110.
- Skip (DEC_SCAN_SKIP_EN, DWELL=0, BLANK_CYC=0):
  - SKIP=0101 -> Y_L alternates 1101/0111, with WRAP on each 1101 after 0111.
  - SKIP=1111 -> Y_L=1111 steady.
